// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
package axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Occupancy of a single-entry AW or W holding slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HELD  = 1'b1
  } slot_t;

  // Read channel: waiting for an address, or presenting a response.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  // Bits needed to index num_regs registers; never less than one.
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axil_wr_join.sv
// Joins the independent AW and W channels into one write commit and runs
// the B handshake. Each channel has a one-entry slot; a commit fires once
// both slots are held and no response is outstanding.
module axil_wr_join
  import axil_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_awaddr,
  input  logic          i_awvalid,
  output logic          o_awready,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_wvalid,
  output logic          o_wready,
  output logic          o_bvalid,
  input  logic          i_bready,
  output logic          o_commit,
  output logic [AW-1:0] o_commit_addr,
  output logic [DW-1:0] o_commit_data
);

  slot_t         r_aw_slot;
  slot_t         r_w_slot;
  logic [AW-1:0] r_awaddr;
  logic [DW-1:0] r_wdata;
  logic          r_bvalid;
  logic          r_awready;
  logic          r_wready;

  logic  w_aw_hs;
  logic  w_w_hs;
  logic  w_commit;
  slot_t w_aw_slot_next;
  slot_t w_w_slot_next;
  logic  w_bvalid_next;

  // Next-state for both slots and the response flag.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    w_aw_slot_next = r_aw_slot;
    w_w_slot_next  = r_w_slot;
    w_bvalid_next  = r_bvalid;

    w_aw_hs  = i_awvalid && r_awready;
    w_w_hs   = i_wvalid && r_wready;
    w_commit = (r_aw_slot == SLOT_HELD) && (r_w_slot == SLOT_HELD) && !r_bvalid;

    // A handshake only happens into an empty slot, so it never coincides
    // with the commit that empties a held one.
    if (w_commit) begin
      w_aw_slot_next = SLOT_EMPTY;
      w_w_slot_next  = SLOT_EMPTY;
      w_bvalid_next  = 1'b1;
    end else begin
      if (w_aw_hs) w_aw_slot_next = SLOT_HELD;
      if (w_w_hs)  w_w_slot_next  = SLOT_HELD;
      if (r_bvalid && i_bready) w_bvalid_next = 1'b0;
    end
  end

  // Slot, payload and registered-ready state.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_slot <= SLOT_EMPTY;
      r_w_slot  <= SLOT_EMPTY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_bvalid  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
    end else begin
      r_aw_slot <= w_aw_slot_next;
      r_w_slot  <= w_w_slot_next;
      r_bvalid  <= w_bvalid_next;
      if (w_aw_hs) r_awaddr <= i_awaddr;
      if (w_w_hs)  r_wdata  <= i_wdata;
      // Readies are registered from the state this edge produces, so they
      // stay low for the first cycle after reset release.
      r_awready <= (w_aw_slot_next == SLOT_EMPTY) && !w_bvalid_next;
      r_wready  <= (w_w_slot_next == SLOT_EMPTY) && !w_bvalid_next;
    end
  end

  assign o_awready     = r_awready;
  assign o_wready      = r_wready;
  assign o_bvalid      = r_bvalid;
  assign o_commit      = w_commit;
  assign o_commit_addr = r_awaddr;
  assign o_commit_data = r_wdata;

endmodule

// File: rtl/axil_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS data-width registers behind a
// single-beat read/write interface, with SLVERR for unmapped words.
module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int NUM_REGS         = 16
) (
  input  logic                                 AXI_ACLK,
  input  logic                                 AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]          AXI_ARADDR,
  input  logic                                 AXI_ARVALID,
  output logic                                 AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]          AXI_RDATA,
  output logic [1:0]                           AXI_RRESP,
  output logic                                 AXI_RVALID,
  input  logic                                 AXI_RREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]          AXI_AWADDR,
  input  logic                                 AXI_AWVALID,
  output logic                                 AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]          AXI_WDATA,
  input  logic                                 AXI_WVALID,
  output logic                                 AXI_WREADY,
  output logic [1:0]                           AXI_BRESP,
  output logic                                 AXI_BVALID,
  input  logic                                 AXI_BREADY,
  output logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] regs_o
);

  localparam int          DW         = C_AXI_DATA_WIDTH;
  localparam int          ADDR_LSB   = $clog2(DW / 8);
  localparam int          WORD_W     = C_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int          IDX_W      = idx_width(NUM_REGS);
  localparam logic [31:0] NUM_REGS_U = NUM_REGS;

  // ---------------- write path ----------------
  logic                        w_commit;
  logic [C_AXI_ADDR_WIDTH-1:0] w_commit_addr;
  logic [DW-1:0]               w_commit_data;

  axil_wr_join #(
    .AW (C_AXI_ADDR_WIDTH),
    .DW (DW)
  ) u_wr_join (
    .i_clk         (AXI_ACLK),
    .i_rst_n       (AXI_ARESETN),
    .i_awaddr      (AXI_AWADDR),
    .i_awvalid     (AXI_AWVALID),
    .o_awready     (AXI_AWREADY),
    .i_wdata       (AXI_WDATA),
    .i_wvalid      (AXI_WVALID),
    .o_wready      (AXI_WREADY),
    .o_bvalid      (AXI_BVALID),
    .i_bready      (AXI_BREADY),
    .o_commit      (w_commit),
    .o_commit_addr (w_commit_addr),
    .o_commit_data (w_commit_data)
  );

  // Decode: byte offset dropped, word index compared against NUM_REGS.
  logic [WORD_W-1:0] w_wr_word;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_unused_addr_bits;

  assign w_wr_word = w_commit_addr[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign w_rd_word = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign w_wr_ok   = 32'(w_wr_word) < NUM_REGS_U;
  assign w_rd_ok   = 32'(w_rd_word) < NUM_REGS_U;
  assign w_wr_idx  = w_wr_word[IDX_W-1:0];
  assign w_rd_idx  = w_rd_word[IDX_W-1:0];
  // Byte-offset bits carry no information for word-wide registers.
  assign w_unused_addr_bits = ^{w_commit_addr[ADDR_LSB-1:0], AXI_ARADDR[ADDR_LSB-1:0]};

  logic [DW-1:0] r_regs [NUM_REGS];
  resp_t         r_bresp;

  // Register array update on an in-range commit.
  // NOTE: the register array is reset explicitly because its contents are
  // architecturally visible on regs_o; a RAM-style array would skip this.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && w_wr_ok) begin
      r_regs[w_wr_idx] <= w_commit_data;
    end
  end

  // Write response code, captured with the commit and held while BVALID.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_bresp <= RESP_OKAY;
    end else if (w_commit) begin
      r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign AXI_BRESP = r_bresp;

  // ---------------- read path ----------------
  rd_state_t     r_rd_state;
  rd_state_t     w_rd_state_next;
  logic          w_ar_hs;
  logic          r_arready;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  resp_t         r_rresp;

  // Read FSM state register.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) r_rd_state <= RD_IDLE;
    else              r_rd_state <= w_rd_state_next;
  end

  // Read FSM next state: accept an address in IDLE, retire on RREADY.
  always_comb begin
    w_rd_state_next = r_rd_state;
    w_ar_hs         = AXI_ARVALID && r_arready;
    case (r_rd_state)
      RD_IDLE: if (w_ar_hs)    w_rd_state_next = RD_RESP;
      RD_RESP: if (AXI_RREADY) w_rd_state_next = RD_IDLE;
      default:                 w_rd_state_next = RD_IDLE;
    endcase
  end

  // Registered read outputs; a same-edge write commit is not yet visible
  // in r_regs, so a colliding read returns the old value.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= (w_rd_state_next == RD_IDLE);
      r_rvalid  <= (w_rd_state_next == RD_RESP);
      if (w_ar_hs) begin
        r_rdata <= w_rd_ok ? r_regs[w_rd_idx] : '0;
        r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign AXI_ARREADY = r_arready;
  assign AXI_RVALID  = r_rvalid;
  assign AXI_RDATA   = r_rdata;
  assign AXI_RRESP   = r_rresp;

  // Flattened register view for the surrounding fabric.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DW +: DW] = r_regs[g];
  end

endmodule

// File: tb/tb_axil_slave_regs.sv
// Directed self-checking bench for axil_slave_regs (32-bit data, 16 regs).
module tb_axil_slave_regs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [7:0]   awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [511:0] regs_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  axil_slave_regs #(
    .C_AXI_DATA_WIDTH (32),
    .C_AXI_ADDR_WIDTH (8),
    .NUM_REGS         (16)
  ) dut (
    .AXI_ACLK    (clk),
    .AXI_ARESETN (rst_n),
    .AXI_ARADDR  (araddr),
    .AXI_ARVALID (arvalid),
    .AXI_ARREADY (arready),
    .AXI_RDATA   (rdata),
    .AXI_RRESP   (rresp),
    .AXI_RVALID  (rvalid),
    .AXI_RREADY  (rready),
    .AXI_AWADDR  (awaddr),
    .AXI_AWVALID (awvalid),
    .AXI_AWREADY (awready),
    .AXI_WDATA   (wdata),
    .AXI_WVALID  (wvalid),
    .AXI_WREADY  (wready),
    .AXI_BRESP   (bresp),
    .AXI_BVALID  (bvalid),
    .AXI_BREADY  (bready),
    .regs_o      (regs_o)
  );

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s.word%0d", tag, i), {32'h0, regs_o[i*32 +: 32]}, {32'h0, model[i]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".arready"}, 64'(arready), 64'h0);
    check({tag, ".rvalid"},  64'(rvalid),  64'h0);
    check({tag, ".rdata"},   64'(rdata),   64'h0);
    check({tag, ".rresp"},   64'(rresp),   64'h0);
    check({tag, ".awready"}, 64'(awready), 64'h0);
    check({tag, ".wready"},  64'(wready),  64'h0);
    check({tag, ".bvalid"},  64'(bvalid),  64'h0);
    check({tag, ".bresp"},   64'(bresp),   64'h0);
    check({tag, ".regs_o"},  64'(regs_o === '0), 64'h1);
  endtask

  // Full write transaction with bounded waits; returns BRESP.
  task automatic wr(input logic [7:0] addr, input logic [31:0] data, output logic [1:0] resp);
    bit aw_done;
    bit w_done;
    bit aw_hs;
    bit w_hs;
    int budget;
    aw_done = 1'b0;
    w_done  = 1'b0;
    budget  = 0;
    awaddr  = addr;
    wdata   = data;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    while (!(aw_done && w_done) && budget < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      budget++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check($sformatf("wr%0h.handshakes", addr), {62'h0, aw_done, w_done}, 64'h3);
    budget = 0;
    while (!bvalid && budget < 20) begin
      tick();
      budget++;
    end
    check($sformatf("wr%0h.bvalid", addr), 64'(bvalid), 64'h1);
    resp   = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check($sformatf("wr%0h.bvalid_clear", addr), 64'(bvalid), 64'h0);
  endtask

  // Full read transaction; RVALID must follow the AR handshake by one cycle.
  task automatic rd(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int budget;
    hs      = 1'b0;
    budget  = 0;
    araddr  = addr;
    arvalid = 1'b1;
    while (!hs && budget < 20) begin
      hs = arready;
      tick();
      budget++;
    end
    arvalid = 1'b0;
    check($sformatf("rd%0h.ar_hs", addr), 64'(hs), 64'h1);
    check($sformatf("rd%0h.rvalid", addr), 64'(rvalid), 64'h1);
    data   = rdata;
    resp   = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check($sformatf("rd%0h.rvalid_clear", addr), 64'(rvalid), 64'h0);
    check($sformatf("rd%0h.arready", addr), 64'(arready), 64'h1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    rst_n = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;

    // Reset, then the first cycle after release: everything is zero.
    tick(); tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    check_all_zero("release");
    tick();
    check("ready.ar", 64'(arready), 64'h1);
    check("ready.aw", 64'(awready), 64'h1);
    check("ready.w",  64'(wready),  64'h1);

    // 1) AW and W together to 0x08: BVALID exactly two cycles later.
    awaddr = 8'h08; wdata = 32'hDEADBEEF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1.k1.awready", 64'(awready), 64'h0);
    check("t1.k1.wready",  64'(wready),  64'h0);
    check("t1.k1.bvalid",  64'(bvalid),  64'h0);
    tick();
    model[2] = 32'hDEADBEEF;
    check("t1.k2.bvalid", 64'(bvalid), 64'h1);
    check("t1.k2.bresp",  64'(bresp),  64'h0);
    check_regs("t1.k2");
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("t1.b.bvalid",  64'(bvalid),  64'h0);
    check("t1.b.awready", 64'(awready), 64'h1);
    check("t1.b.wready",  64'(wready),  64'h1);
    rd(8'h08, d, r);
    check("t1.rdata", 64'(d), 64'hDEADBEEF);
    check("t1.rresp", 64'(r), 64'h0);

    // 2) W three cycles before AW.
    wdata = 32'h12345678; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2.wait%0d.wready", i), 64'(wready), 64'h0);
      check($sformatf("t2.wait%0d.awready", i), 64'(awready), 64'h1);
      check($sformatf("t2.wait%0d.bvalid", i), 64'(bvalid), 64'h0);
      if (i == 2) begin
        awaddr = 8'h04; awvalid = 1'b1;
      end
      tick();
    end
    awvalid = 1'b0;
    check("t2.k1.bvalid", 64'(bvalid), 64'h0);
    tick();
    model[1] = 32'h12345678;
    check("t2.k2.bvalid", 64'(bvalid), 64'h1);
    check("t2.k2.bresp",  64'(bresp),  64'h0);
    check_regs("t2.k2");
    bready = 1'b1;
    tick();
    bready = 1'b0;
    tick(); tick();
    check("t2.single_commit", 64'(bvalid), 64'h0);

    // 3) Out-of-range write and read at 0x40.
    wr(8'h40, 32'hCAFEF00D, r);
    check("t3.bresp", 64'(r), 64'h2);
    check_regs("t3");
    rd(8'h40, d, r);
    check("t3.rdata", 64'(d), 64'h0);
    check("t3.rresp", 64'(r), 64'h2);

    // 4) BREADY held low for 4 cycles while a second write waits.
    awaddr = 8'h10; wdata = 32'h0BADF00D; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awaddr = 8'h14; wdata = 32'h77778888;
    tick();
    model[4] = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4.hold%0d.bvalid", i),  64'(bvalid),  64'h1);
      check($sformatf("t4.hold%0d.bresp", i),   64'(bresp),   64'h0);
      check($sformatf("t4.hold%0d.awready", i), 64'(awready), 64'h0);
      check($sformatf("t4.hold%0d.wready", i),  64'(wready),  64'h0);
      tick();
    end
    check_regs("t4.hold");
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("t4.b.bvalid",  64'(bvalid),  64'h0);
    check("t4.b.awready", 64'(awready), 64'h1);
    check("t4.b.wready",  64'(wready),  64'h1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    model[5] = 32'h77778888;
    check("t4.w2.bvalid", 64'(bvalid), 64'h1);
    check_regs("t4.w2");
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // 5) Read of 0x0C on the same edge a write commits to it.
    wr(8'h0C, 32'h11111111, r);
    model[3] = 32'h11111111;
    awaddr = 8'h0C; wdata = 32'hA5A5A5A5; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t5.k1.arready", 64'(arready), 64'h1);
    araddr = 8'h0C; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    model[3] = 32'hA5A5A5A5;
    check("t5.rvalid", 64'(rvalid), 64'h1);
    check("t5.rdata",  64'(rdata),  64'h11111111);
    check("t5.rresp",  64'(rresp),  64'h0);
    check("t5.bvalid", 64'(bvalid), 64'h1);
    check_regs("t5");
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    check("t5.rvalid_clear", 64'(rvalid), 64'h0);
    check("t5.bvalid_clear", 64'(bvalid), 64'h0);
    rd(8'h0C, d, r);
    check("t5.reread", 64'(d), 64'hA5A5A5A5);

    // 6) Reset pulsed while RVALID=1 and the AW slot is held.
    araddr = 8'h08; arvalid = 1'b1; awaddr = 8'h18; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    check("t6.pre.rvalid",  64'(rvalid),  64'h1);
    check("t6.pre.awready", 64'(awready), 64'h0);
    check("t6.pre.wready",  64'(wready),  64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    check_all_zero("t6.async");
    tick();
    check_all_zero("t6.held");
    rst_n = 1'b1;
    check_all_zero("t6.release");
    tick();
    wr(8'h08, 32'h5A5A5A5A, r);
    model[2] = 32'h5A5A5A5A;
    check("t6.bresp", 64'(r), 64'h0);
    check_regs("t6");
    rd(8'h08, d, r);
    check("t6.rdata", 64'(d), 64'h5A5A5A5A);
    check("t6.rresp", 64'(r), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
